instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 192 +++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Byte-stream loader for the instruction memory. Receives a
//                16-bit little-endian word count followed by N little-endian
//                32-bit words and writes them to consecutive word addresses,
//                holding the CPU stalled (busy) while the load is running.
//                Optional feature macro: LOADER_CHECKSUM_EN adds a trailing
//                XOR checksum byte, checked in state CHK.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd6;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_count;
    logic [31:0] r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_word;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_too_long;
    logic        w_last;

    // The count high byte is only meaningful on the LEN1 accepting edge
    assign w_accept   = byte_valid && byte_ready;
    assign w_len      = {byte_data, r_count[7:0]};
    assign w_too_long = ({16'd0, w_len} > 32'(DEPTH));
    assign w_last     = ((r_idx + 32'd1) == {16'd0, r_count});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LEN0;
            S_LEN0:  if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if (w_too_long)
                        w_next = S_FIN;
                    else if (w_len == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_FIN;
`endif
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA:  if (w_accept && (r_bcnt == 2'd3)) w_next = S_WRITE;
            S_WRITE: begin
                if (w_last)
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_FIN;
`endif
                else
                    w_next = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK:   if (w_accept) w_next = S_FIN;
`endif
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_LEN0, S_LEN1, S_DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                  byte_ready = 1'b1;
`endif
            S_WRITE:                mem_we     = 1'b1;
            default:                ;
        endcase
    end

    // Datapath: length capture, word assembly, write-port registers, status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
            r_idx   <= 32'd0;
            r_bcnt  <= 2'd0;
            r_word  <= 24'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor   <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx  <= 32'd0;
                        r_bcnt <= 2'd0;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_xor  <= 8'd0;
`endif
                    end
                end
                S_LEN0: if (w_accept) r_count[7:0] <= byte_data;
                S_LEN1: begin
                    if (w_accept) begin
                        r_count[15:8] <= byte_data;
                        if (w_too_long) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor  <= r_xor ^ byte_data;
`endif
                        // Fourth byte completes the word: present it on the write port
                        if (r_bcnt == 2'd3) begin
                            r_addr  <= r_idx;
                            r_wdata <= {byte_data, r_word};
                        end else begin
                            r_word[{r_bcnt, 3'b000} +: 8] <= byte_data;
                        end
                    end
                end
                // Index saturates at N-1 so it never points past the load
                S_WRITE: if (!w_last) r_idx <= r_idx + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                S_CHK:   if (w_accept) r_err <= (byte_data != r_xor);
`endif
                S_FIN:   r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Scoreboard bench for instr_mem_loader. Stimulus pushes the
//                expected memory writes and final status into queues; a
//                negedge monitor pops and compares them as the DUT produces
//                writes and finishes loads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    instr_mem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wq[$];   // expected writes {addr, data}
    bit          sq[$];   // expected err at end of each load
    bit          prev_busy = 1'b0;
    bit          start_in_gaps = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares each write-port pulse and each end-of-load status
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    logic [63:0] e;
                    e = wq.pop_front();
                    check("write_addr", mem_addr, e[63:32]);
                    check("write_data", mem_wdata, e[31:0]);
                    check("ready_in_write", {31'd0, byte_ready}, 32'd0);
                end
            end
            if (prev_busy && !busy) begin
                if (sq.size() == 0) begin
                    check("unexpected_finish", 32'd1, 32'd0);
                end else begin
                    bit e_err;
                    e_err = sq.pop_front();
                    check("done", {31'd0, done}, 32'd1);
                    check("err", {31'd0, err}, {31'd0, e_err});
                end
            end
        end
        prev_busy = busy;
    end

    // One byte with an optional idle gap before it; bounded handshake wait
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        int n;
        for (int k = 0; k < gap; k++) begin
            byte_valid = 1'b0;
            start      = start_in_gaps;
            @(posedge clk); #1;
            start      = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            r = byte_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 100);
        if (!r) check("byte_handshake_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    endfunction

    // Complete load: model computes expected writes/status, then the stream is driven
    task automatic run_load(input logic [15:0] n, input logic [31:0] words[$],
                            input int gap, input logic [7:0] chk_delta);
        logic [7:0]  x;
        logic [31:0] w;
        bit          oversize;
        oversize = (int'(n) > DEPTH);
        x = 8'h00;
        if (!oversize)
            for (int i = 0; i < int'(n); i++) begin
                w = words[i];
                wq.push_back({i[31:0], w});
                x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
`ifdef LOADER_CHECKSUM_EN
        sq.push_back(oversize || (chk_delta != 8'h00));
`else
        sq.push_back(oversize);
`endif
        do_start();
        send_byte(n[7:0], pick_gap(gap));
        send_byte(n[15:8], pick_gap(gap));
        if (oversize) begin
            @(negedge clk);
            check("ready_after_oversize_len", {31'd0, byte_ready}, 32'd0);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = words[i];
                for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], pick_gap(gap));
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(x ^ chk_delta, pick_gap(gap));
`endif
        end
        wait_idle();
    endtask

    logic [31:0] wl[$];

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_outs",  {29'd0, mem_we, done, err}, 32'd0);
        check("rst_addr",  mem_addr | mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-word directed load
        wl = '{32'h0000_0013, 32'h0010_0093};
        run_load(16'd2, wl, 0, 8'h00);
        check("done_hold", {31'd0, done}, 32'd1);

        // Empty load
        wl = '{};
        run_load(16'd0, wl, 0, 8'h00);

        // Oversized count: DEPTH+1
        run_load(16'(DEPTH + 1), wl, 0, 8'h00);

        // Alternate valid cycles with start pulsed mid-load
        start_in_gaps = 1'b1;
        wl = '{32'h1234_5678};
        run_load(16'd1, wl, 1, 8'h00);
        start_in_gaps = 1'b0;

        // Reset after two bytes of the second word
        wq.push_back({32'd0, 32'hCAFE_F00D});
        do_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h0D, 0); send_byte(8'hF0, 0); send_byte(8'hFE, 0); send_byte(8'hCA, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, byte_ready}, 32'd0);
        check("midrst_flags", {28'd0, mem_we, busy, done, err}, 32'd0);
        check("midrst_addr",  mem_addr, 32'd0);
        check("midrst_wdata", mem_wdata, 32'd0);
        check("midrst_pending", wq.size(), 32'd0);
        wq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wl = '{32'hDDCC_BBAA};
        run_load(16'd1, wl, 0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
        wl = '{32'h0804_0201};
        run_load(16'd1, wl, 0, 8'h00);
        run_load(16'd1, wl, 0, 8'h01);
`endif

        // Randomized loads
        for (int t = 0; t < 8; t++) begin
            int n;
            n = int'($urandom_range(1, 6));
            wl = '{};
            for (int i = 0; i < n; i++) wl.push_back($urandom);
            run_load(16'(n), wl, -1, ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
        end

        // Full-depth boundary load
        wl = '{};
        for (int i = 0; i < DEPTH; i++) wl.push_back($urandom);
        run_load(16'(DEPTH), wl, 0, 8'h00);

        check("writes_drained", wq.size(), 32'd0);
        check("status_drained", sq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
